timer_counter: RTL and testbench

- Memory-mapped timer/counter (TC) peripheral. It is the responder for the CPU's M-stage load/store accesses in the 0x7f00–0x7f0b window (instance 0) and the 0x7f10–0x7f1b window (instance 1).
- The CPU-side exception check already rejects sub-word TC accesses and stores to COUNT. This block only ever sees word-aligned lw/sw.
- It produces an interrupt request for the CP0 hardware-interrupt input.

---
 rtl/timer_counter_pkg.sv | 30 +++
 rtl/timer_counter.sv | 124 ++++++++++++
 tb/tb_timer_counter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped timer/counter: register offsets,
// FSM state codes, mode codes, instance base addresses and the CTRL field layout.
package timer_counter_pkg;

    localparam int unsigned TC_DATA_W  = 32;
    localparam int unsigned TC_STATE_W = 2;

    // Word offsets selected by addr[3:2]
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    localparam logic [TC_STATE_W-1:0] TC_IDLE = 2'd0;
    localparam logic [TC_STATE_W-1:0] TC_LOAD = 2'd1;
    localparam logic [TC_STATE_W-1:0] TC_CNT  = 2'd2;
    localparam logic [TC_STATE_W-1:0] TC_INT  = 2'd3;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

    localparam logic [TC_DATA_W-1:0] TC_BASE0 = 32'h0000_7f00;
    localparam logic [TC_DATA_W-1:0] TC_BASE1 = 32'h0000_7f10;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tcCtrl_t;

endpackage

// File: rtl/timer_counter.sv
// Timer/counter peripheral: CTRL/PRESET/COUNT register window with a
// down-count FSM and masked interrupt. Optional TC_STATUS_RDBACK_EN exposes
// FSM state and the raw interrupt flag in CTRL read data.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [TC_DATA_W-1:0] BASE_ADDR = TC_BASE0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TC_DATA_W-1:0] addr,
    input  logic                 we,
    input  logic [TC_DATA_W-1:0] wdata,
    output logic [TC_DATA_W-1:0] rdata,
    output logic                 irq
);

    logic [TC_STATE_W-1:0] state, stateNext;
    tcCtrl_t               ctrl, ctrlNext;
    logic [TC_DATA_W-1:0]  preset, presetNext;
    logic [TC_DATA_W-1:0]  count, countNext;
    logic                  irqFlag, flagNext;

    logic       hit;
    logic [1:0] regSel;
    logic       wrCtrl;
    logic       wrPreset;
    logic       enEff;
    logic       unusedAddrLsb;

    assign hit           = (addr[TC_DATA_W-1:4] == BASE_ADDR[TC_DATA_W-1:4]);
    assign regSel        = addr[3:2];
    assign wrCtrl        = we && hit && (regSel == TC_CTRL);
    assign wrPreset      = we && hit && (regSel == TC_PRESET);
    assign unusedAddrLsb = ^addr[1:0];

    // Enable seen by the FSM this cycle: a CTRL write acts on the same edge
    assign enEff = wrCtrl ? wdata[0] : ctrl.en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= TC_IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            irqFlag <= 1'b0;
        end else begin
            state   <= stateNext;
            ctrl    <= ctrlNext;
            preset  <= presetNext;
            count   <= countNext;
            irqFlag <= flagNext;
        end
    end

    always_comb begin
        stateNext  = state;
        ctrlNext   = ctrl;
        presetNext = preset;
        countNext  = count;
        flagNext   = irqFlag;

        case (state)
            TC_IDLE: begin
                if (enEff) begin
                    stateNext = TC_LOAD;
                    flagNext  = 1'b0;
                end
            end
            TC_LOAD: begin
                countNext = preset;
                stateNext = TC_CNT;
            end
            TC_CNT: begin
                if (!enEff) begin
                    stateNext = TC_IDLE;
                end else if (count > TC_DATA_W'(1)) begin
                    countNext = count - TC_DATA_W'(1);
                end else begin
                    // Reaching zero always leaves CNT, so the decrement never wraps
                    countNext = '0;
                    flagNext  = 1'b1;
                    stateNext = TC_INT;
                end
            end
            TC_INT: begin
                stateNext = TC_IDLE;
                if (ctrl.mode == TC_MODE_ONESHOT) begin
                    ctrlNext.en = 1'b0;
                end else begin
                    flagNext = 1'b0;
                end
            end
            default: stateNext = TC_IDLE;
        endcase

        // Software writes override the FSM's own enable clear
        if (wrCtrl) begin
            ctrlNext = tcCtrl_t'(wdata[3:0]);
        end
        if (wrPreset) begin
            presetNext = wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (regSel)
`ifdef TC_STATUS_RDBACK_EN
                TC_CTRL:   rdata = {25'b0, irqFlag, state, ctrl};
`else
                TC_CTRL:   rdata = {28'b0, ctrl};
`endif
                TC_PRESET: rdata = preset;
                TC_COUNT:  rdata = count;
                default:   rdata = '0;
            endcase
        end
    end

    assign irq = irqFlag & ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: table of per-cycle bus vectors plus
// hand-written sequences, all checked through an expected-value queue.
module tb_timer_counter;
    import timer_counter_pkg::*;

    localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
    localparam logic [31:0] A_PRESET = 32'h0000_7f04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7f08;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] expR;
        logic        expI;
    } vec_t;

    typedef struct {
        logic [31:0] expR;
        logic        expI;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1;

    exp_t sb[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    timer_counter #(.BASE_ADDR(TC_BASE0)) u0 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata0), .irq(irq0)
    );

    timer_counter #(.BASE_ADDR(TC_BASE1)) u1 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata1), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected CTRL read value for a given ctrl/state/flag
    function automatic logic [31:0] rb(input logic [3:0] c, input logic [1:0] st, input logic f);
`ifdef TC_STATUS_RDBACK_EN
        return {25'b0, f, st, c};
`else
        return {28'b0, c} | 32'(0 & {f, st});
`endif
    endfunction

    task automatic checkHead();
        exp_t e;
        logic [31:0] rd;
        e  = sb.pop_front();
        rd = rdata0 | rdata1;
        checks++;
        if (rd !== e.expR || irq0 !== e.expI) begin
            errors++;
            $display("FAIL %s: rdata=%h irq=%b, expected rdata=%h irq=%b",
                     e.name, rd, irq0, e.expR, e.expI);
        end
    endtask

    // One bus cycle: drive at negedge, check current state, let the edge apply
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] er, input logic ei, input string nm);
        addr  = a;
        we    = w;
        wdata = d;
        sb.push_back('{er, ei, nm});
        #1;
        checkHead();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;

        // One-shot run, masked one-shot, re-enable clear, disable during CNT
        vecs.push_back('{A_PRESET, 1'b1, 32'd3, 32'd0,        1'b0});
        vecs.push_back('{A_CTRL,   1'b1, 32'h9, rb(4'h0,2'd0,1'b0), 1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd0,        1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd3,        1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd2,        1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd1,        1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd0,        1'b1});
        vecs.push_back('{A_CTRL,   1'b0, 32'd0, rb(4'h8,2'd0,1'b1), 1'b1});
        vecs.push_back('{A_CTRL,   1'b0, 32'd0, rb(4'h8,2'd0,1'b1), 1'b1});
        vecs.push_back('{A_CTRL,   1'b1, 32'h1, rb(4'h8,2'd0,1'b1), 1'b1});
        vecs.push_back('{A_CTRL,   1'b0, 32'd0, rb(4'h1,2'd1,1'b0), 1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd3,        1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd2,        1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd1,        1'b0});
        vecs.push_back('{A_CTRL,   1'b0, 32'd0, rb(4'h1,2'd3,1'b1), 1'b0});
        vecs.push_back('{A_CTRL,   1'b0, 32'd0, rb(4'h0,2'd0,1'b1), 1'b0});
        vecs.push_back('{A_CTRL,   1'b1, 32'h9, rb(4'h0,2'd0,1'b1), 1'b0});
        vecs.push_back('{A_CTRL,   1'b0, 32'd0, rb(4'h9,2'd1,1'b0), 1'b0});
        vecs.push_back('{A_CTRL,   1'b1, 32'h0, rb(4'h9,2'd2,1'b0), 1'b0});
        vecs.push_back('{A_COUNT,  1'b0, 32'd0, 32'd3,        1'b0});
        vecs.push_back('{A_CTRL,   1'b0, 32'd0, rb(4'h0,2'd0,1'b0), 1'b0});

        repeat (3) @(negedge clk);
        step(A_CTRL,   1'b0, 32'd0, 32'd0, 1'b0, "reset_ctrl");
        step(A_COUNT,  1'b0, 32'd0, 32'd0, 1'b0, "reset_count");
        reset = 1'b1;
        @(negedge clk);
        step(A_PRESET, 1'b0, 32'd0, 32'd0, 1'b0, "post_reset_preset");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].expR, vecs[i].expI,
                 $sformatf("vec%0d", i));
        end

        // Auto-reload with PRESET=2: irq one cycle every 5 cycles
        step(A_PRESET, 1'b1, 32'd2, 32'd3, 1'b0, "reload_preset");
        step(A_CTRL, 1'b1, 32'hB, rb(4'h0,2'd0,1'b0), 1'b0, "reload_enable");
        for (int k = 1; k <= 15; k++) begin
            logic [31:0] er;
            er = (k == 1) ? 32'd3 : (k % 5 == 2) ? 32'd2 : (k % 5 == 3) ? 32'd1 : 32'd0;
            step(A_COUNT, 1'b0, 32'd0, er, (k % 5 == 4), $sformatf("reload_k%0d", k));
        end
        step(A_CTRL,  1'b1, 32'h0, rb(4'hB,2'd1,1'b0), 1'b0, "reload_disable");
        step(A_COUNT, 1'b0, 32'd0, 32'd2, 1'b0, "reload_cnt_stop");
        step(A_COUNT, 1'b0, 32'd0, 32'd2, 1'b0, "reload_idle_hold");

        // Address decode and instance separation
        step(A_COUNT,      1'b1, 32'h1234, 32'd2, 1'b0, "wr_count_ro");
        step(32'h7f20,     1'b1, 32'h1234, 32'd0, 1'b0, "wr_miss");
        step(A_COUNT,      1'b0, 32'd0,    32'd2, 1'b0, "count_unchanged");
        step(A_PRESET,     1'b0, 32'd0,    32'd2, 1'b0, "preset_unchanged");
        step(32'h7f14,     1'b1, 32'h55,   32'd0, 1'b0, "u1_preset_wr");
        step(32'h7f14,     1'b0, 32'd0,    32'h55, 1'b0, "u1_preset_rd");
        step(A_PRESET,     1'b0, 32'd0,    32'd2, 1'b0, "u0_preset_indep");
        step(32'h7f1c,     1'b0, 32'd0,    32'd0, 1'b0, "u1_reserved");

        // PRESET write during CNT, CTRL write in the one-shot INT cycle
        step(A_PRESET, 1'b1, 32'd4, 32'd2, 1'b0, "col_preset4");
        step(A_CTRL,   1'b1, 32'h1, rb(4'h0,2'd0,1'b0), 1'b0, "col_enable");
        step(A_COUNT,  1'b0, 32'd0, 32'd2, 1'b0, "col_load");
        step(A_PRESET, 1'b1, 32'd7, 32'd4, 1'b0, "col_preset7");
        step(A_COUNT,  1'b0, 32'd0, 32'd3, 1'b0, "col_cnt3");
        step(A_COUNT,  1'b0, 32'd0, 32'd2, 1'b0, "col_cnt2");
        step(A_COUNT,  1'b0, 32'd0, 32'd1, 1'b0, "col_cnt1");
        step(A_CTRL,   1'b1, 32'h1, rb(4'h1,2'd3,1'b1), 1'b0, "col_int_wr");
        step(A_CTRL,   1'b0, 32'd0, rb(4'h1,2'd0,1'b1), 1'b0, "col_en_kept");
        step(A_PRESET, 1'b0, 32'd0, 32'd7, 1'b0, "col_load7");
        step(A_COUNT,  1'b0, 32'd0, 32'd7, 1'b0, "col_cnt7");
        step(A_COUNT,  1'b0, 32'd0, 32'd6, 1'b0, "col_cnt6");

        // Asynchronous reset with count=5
        addr  = A_COUNT;
        we    = 1'b0;
        reset = 1'b0;
        sb.push_back('{32'd0, 1'b0, "async_reset"});
        #1;
        checkHead();
        @(negedge clk);
        reset = 1'b1;
        step(A_CTRL,   1'b0, 32'd0, rb(4'h0,2'd0,1'b0), 1'b0, "after_reset_ctrl");
        step(A_COUNT,  1'b0, 32'd0, 32'd0, 1'b0, "after_reset_count");
        step(A_PRESET, 1'b0, 32'd0, 32'd0, 1'b0, "after_reset_preset");
        step(32'h7f14, 1'b0, 32'd0, 32'd0, 1'b0, "after_reset_u1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
